// File: rtl/daq_rate_pkg.sv
// Shared state codes and K28.5 word decode for the DAQ rate-change responder.
// Pure definitions: no latency, no flow control.
package daq_rate_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_RATE_DONE = 3'd2,
        ST_CDV_HUNT  = 3'd3,
        ST_CDV_COUNT = 3'd4,
        ST_CDV_OK    = 3'd5,
        ST_CDV_FAIL  = 3'd6
    } rsp_state_t;

    localparam logic [7:0] K28_5_LSB    = 8'hBC;
    localparam logic [3:0] WORD_CNT_MAX = 4'd15;

    // kchar[1] flags a code violation or disparity error from the PCS.
    function automatic logic good_word(input logic [7:0] data_lsb, input logic [1:0] kchar);
        return !kchar[1] && (!kchar[0] || (data_lsb == K28_5_LSB));
    endfunction

    function automatic logic is_comma(input logic [7:0] data_lsb, input logic [1:0] kchar);
        return kchar[0] && (data_lsb == K28_5_LSB);
    endfunction

endpackage

// File: rtl/cdv_word_checker.sv
// Comma/good-word decode with good-word and timeout counters; pass/timeout are same-cycle
// decodes of the current word, counters update on the next edge; no backpressure.
module cdv_word_checker
    import daq_rate_pkg::*;
#(
    parameter int CDV_WORDS   = 12,
    parameter int CDV_TIMEOUT = 200
) (
    input  logic        wrd_clk,
    input  logic        clr_cnt_rst,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_kchar,
    input  logic        clr,
    input  logic        hunt,
    input  logic        count,
    output logic        pass,
    output logic        timeout,
    output logic        comma_hit,
    output logic        word_bad,
    output logic [3:0]  cnt
);

    localparam logic [3:0] WORDS_TGT = 4'(CDV_WORDS);
    localparam logic [7:0] TMO_LAST  = 8'(CDV_TIMEOUT - 1);

    logic       comma;
    logic       good;
    logic [3:0] cnt_inc;
    logic [7:0] tmo_cnt;
    logic       unused_hi;

    // Only the K28.5 byte lane matters for alignment; the upper byte is payload.
    assign unused_hi = ^rx_data[15:8];

    assign comma     = is_comma(rx_data[7:0], rx_kchar);
    assign good      = good_word(rx_data[7:0], rx_kchar);
    assign cnt_inc   = (cnt == WORD_CNT_MAX) ? cnt : cnt + 4'd1;
    assign comma_hit = hunt && comma;
    assign word_bad  = count && !good;
    assign pass      = (comma_hit && (WORDS_TGT == 4'd1)) ||
                       (count && good && (cnt_inc == WORDS_TGT));
    assign timeout   = (hunt || count) && (tmo_cnt == TMO_LAST);

    always_ff @(posedge wrd_clk or posedge clr_cnt_rst) begin
        if (clr_cnt_rst) begin
            cnt     <= '0;
            tmo_cnt <= '0;
        end else if (clr) begin
            cnt     <= '0;
            tmo_cnt <= '0;
        end else begin
            if (hunt || count) begin
                tmo_cnt <= (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
            end
            if (comma_hit) begin
                cnt <= 4'd1;
            end else if (count) begin
                cnt <= good ? cnt_inc : 4'd0;
            end
        end
    end

endmodule

// File: rtl/daq_rate_change_responder.sv
// GTX-side responder: settles after a rate_sel change, then runs the clock/data-valid check.
// txratedone rises RATE_SETTLE edges after the change; level handshake, no backpressure.
module daq_rate_change_responder
    import daq_rate_pkg::*;
#(
    parameter int RATE_SETTLE = 8,
    parameter int CDV_WORDS   = 12,
    parameter int CDV_TIMEOUT = 200
) (
    input  logic        wrd_clk,
    input  logic        clr_cnt_rst,
    input  logic [1:0]  rate_sel,
    input  logic        cdv_init,
    input  logic        pcsrst,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_kchar,
    output logic        txratedone,
    output logic        cdv_done,
    output logic        cdv_fail,
    output logic [1:0]  active_rate,
    output logic [3:0]  word_cnt,
    output logic [2:0]  rsp_state
);

    localparam logic [7:0] SETTLE_LAST = 8'(RATE_SETTLE - 1);

    rsp_state_t state;
    logic [1:0] rate_sel_q;
    logic [7:0] settle_cnt;
    logic       rate_chg;
    logic       in_check;
    logic       chk_clr;
    logic       chk_hunt;
    logic       chk_count;
    logic       pass;
    logic       timeout;
    logic       comma_hit;
    logic       word_bad;

    assign rate_chg  = (rate_sel != rate_sel_q);
    assign in_check  = (state == ST_CDV_HUNT) || (state == ST_CDV_COUNT);
    assign chk_clr   = rate_chg || ((state == ST_RATE_DONE) && cdv_init) || (in_check && pcsrst);
    // Counters advance only when the FSM will honour the word this cycle.
    assign chk_hunt  = !rate_chg && !pcsrst && cdv_init && (state == ST_CDV_HUNT);
    assign chk_count = !rate_chg && !pcsrst && cdv_init && (state == ST_CDV_COUNT);
    assign rsp_state = state;

    cdv_word_checker #(
        .CDV_WORDS   (CDV_WORDS),
        .CDV_TIMEOUT (CDV_TIMEOUT)
    ) u_chk (
        .wrd_clk     (wrd_clk),
        .clr_cnt_rst (clr_cnt_rst),
        .rx_data     (rx_data),
        .rx_kchar    (rx_kchar),
        .clr         (chk_clr),
        .hunt        (chk_hunt),
        .count       (chk_count),
        .pass        (pass),
        .timeout     (timeout),
        .comma_hit   (comma_hit),
        .word_bad    (word_bad),
        .cnt         (word_cnt)
    );

    always_ff @(posedge wrd_clk or posedge clr_cnt_rst) begin
        if (clr_cnt_rst) begin
            state       <= ST_IDLE;
            rate_sel_q  <= '0;
            settle_cnt  <= '0;
            txratedone  <= 1'b0;
            cdv_done    <= 1'b0;
            cdv_fail    <= 1'b0;
            active_rate <= '0;
        end else if (rate_chg) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            txratedone <= 1'b0;
            cdv_done   <= 1'b0;
            cdv_fail   <= 1'b0;
            rate_sel_q <= rate_sel;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 8'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state       <= ST_RATE_DONE;
                        active_rate <= rate_sel_q;
                        txratedone  <= 1'b1;
                    end
                end
                ST_RATE_DONE: begin
                    txratedone <= 1'b1;
                    if (cdv_init) state <= ST_CDV_HUNT;
                end
                ST_CDV_HUNT, ST_CDV_COUNT: begin
                    if (pcsrst) begin
                        state <= ST_CDV_HUNT;
                    end else if (!cdv_init) begin
                        state <= ST_RATE_DONE;
                    end else if (pass) begin
                        state      <= ST_CDV_OK;
                        cdv_done   <= 1'b1;
                        txratedone <= 1'b1;
                    end else if (timeout) begin
                        state    <= ST_CDV_FAIL;
                        cdv_fail <= 1'b1;
                    end else if (comma_hit) begin
                        state <= ST_CDV_COUNT;
                    end else if (word_bad) begin
                        state <= ST_CDV_HUNT;
                    end
                end
                ST_CDV_OK: begin
                    if (!cdv_init) begin
                        state      <= ST_IDLE;
                        cdv_done   <= 1'b0;
                        txratedone <= 1'b0;
                    end
                end
                ST_CDV_FAIL: begin
                    if (!cdv_init) begin
                        state    <= ST_RATE_DONE;
                        cdv_fail <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_daq_rate_change_responder.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor compares after each edge.
module tb_daq_rate_change_responder;

    localparam int RATE_SETTLE = 8;
    localparam int CDV_WORDS   = 12;
    localparam int CDV_TIMEOUT = 200;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_RDONE = 2, P_HUNT = 3, P_COUNT = 4, P_OK = 5, P_FAIL = 6;

    logic        wrd_clk = 1'b0;
    logic        clr_cnt_rst = 1'b1;
    logic [1:0]  rate_sel;
    logic        cdv_init;
    logic        pcsrst;
    logic [15:0] rx_data;
    logic [1:0]  rx_kchar;
    logic        txratedone;
    logic        cdv_done;
    logic        cdv_fail;
    logic [1:0]  active_rate;
    logic [3:0]  word_cnt;
    logic [2:0]  rsp_state;

    daq_rate_change_responder #(
        .RATE_SETTLE (RATE_SETTLE),
        .CDV_WORDS   (CDV_WORDS),
        .CDV_TIMEOUT (CDV_TIMEOUT)
    ) dut (
        .wrd_clk     (wrd_clk),
        .clr_cnt_rst (clr_cnt_rst),
        .rate_sel    (rate_sel),
        .cdv_init    (cdv_init),
        .pcsrst      (pcsrst),
        .rx_data     (rx_data),
        .rx_kchar    (rx_kchar),
        .txratedone  (txratedone),
        .cdv_done    (cdv_done),
        .cdv_fail    (cdv_fail),
        .active_rate (active_rate),
        .word_cnt    (word_cnt),
        .rsp_state   (rsp_state)
    );

    always #5 wrd_clk = ~wrd_clk;

    typedef struct {
        logic [2:0] st;
        logic       txd;
        logic       done;
        logic       fail;
        logic [1:0] arate;
        logic [3:0] wc;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the handshake described phase by phase with plain integers.
    int m_st, m_rsq, m_settle, m_wc, m_tmo, m_arate;
    bit m_txd, m_done, m_fail;

    logic [1:0] cur_rs;
    logic       cur_ci;

    function automatic void model_reset();
        m_st = P_IDLE; m_rsq = 0; m_settle = 0; m_wc = 0; m_tmo = 0; m_arate = 0;
        m_txd = 0; m_done = 0; m_fail = 0;
    endfunction

    function automatic void model_step(input int rs, input bit ci, input bit pr,
                                       input logic [15:0] d, input logic [1:0] k);
        bit good, comma, passed;
        good   = (k[1] == 1'b0) && ((k[0] == 1'b0) || (d[7:0] == 8'hBC));
        comma  = (k[0] == 1'b1) && (d[7:0] == 8'hBC);
        passed = 0;
        if (rs != m_rsq) begin
            m_st = P_SETTLE; m_settle = 0; m_wc = 0;
            m_txd = 0; m_done = 0; m_fail = 0; m_rsq = rs;
        end else if (m_st == P_SETTLE) begin
            if (m_settle == RATE_SETTLE - 1) begin
                m_st = P_RDONE; m_arate = m_rsq; m_txd = 1;
            end
            m_settle++;
        end else if (m_st == P_RDONE) begin
            m_txd = 1;
            if (ci) begin m_st = P_HUNT; m_tmo = 0; m_wc = 0; end
        end else if (m_st == P_HUNT || m_st == P_COUNT) begin
            if (pr) begin
                m_wc = 0; m_tmo = 0; m_st = P_HUNT;
            end else if (!ci) begin
                m_st = P_RDONE;
            end else begin
                if (m_st == P_HUNT) begin
                    if (comma) begin
                        m_wc = 1; m_st = P_COUNT;
                        if (CDV_WORDS == 1) passed = 1;
                    end
                end else if (good) begin
                    m_wc = (m_wc + 1 > 15) ? 15 : m_wc + 1;
                    if (m_wc == CDV_WORDS) passed = 1;
                end else begin
                    m_wc = 0; m_st = P_HUNT;
                end
                if (passed) begin
                    m_st = P_OK; m_done = 1; m_txd = 1;
                end else if (m_tmo == CDV_TIMEOUT - 1) begin
                    m_st = P_FAIL; m_fail = 1;
                end
                m_tmo++;
            end
        end else if (m_st == P_OK) begin
            if (!ci) begin m_st = P_IDLE; m_done = 0; m_txd = 0; end
        end else if (m_st == P_FAIL) begin
            if (!ci) begin m_st = P_RDONE; m_fail = 0; end
        end
    endfunction

    task automatic drive(input bit pr, input logic [15:0] d, input logic [1:0] k, input string tag);
        exp_t e;
        @(negedge wrd_clk);
        clr_cnt_rst = 1'b0;
        rate_sel = cur_rs; cdv_init = cur_ci; pcsrst = pr; rx_data = d; rx_kchar = k;
        model_step(int'(cur_rs), cur_ci, pr, d, k);
        e.st = 3'(m_st); e.txd = m_txd; e.done = m_done; e.fail = m_fail;
        e.arate = 2'(m_arate); e.wc = 4'(m_wc); e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic word(input string tag);
        drive(1'b0, 16'($urandom), 2'b00, tag);
    endtask

    task automatic comma(input string tag);
        drive(1'b0, {8'($urandom), 8'hBC}, 2'b01, tag);
    endtask

    task automatic do_reset(input string tag);
        @(posedge wrd_clk);
        #2;
        clr_cnt_rst = 1'b1;
        #1;
        checks++;
        if ({rsp_state, txratedone, cdv_done, cdv_fail, active_rate, word_cnt} !== 12'd0) begin
            errors++;
            $display("FAIL %s: got state=%0d txd=%0b done=%0b fail=%0b rate=%0d wcnt=%0d, expected all zero",
                     tag, rsp_state, txratedone, cdv_done, cdv_fail, active_rate, word_cnt);
        end
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge wrd_clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({rsp_state, txratedone, cdv_done, cdv_fail, active_rate, word_cnt} !==
                    {e.st, e.txd, e.done, e.fail, e.arate, e.wc}) begin
                    errors++;
                    $display("FAIL %s: got state=%0d txd=%0b done=%0b fail=%0b rate=%0d wcnt=%0d, expected state=%0d txd=%0b done=%0b fail=%0b rate=%0d wcnt=%0d",
                             e.tag, rsp_state, txratedone, cdv_done, cdv_fail, active_rate, word_cnt,
                             e.st, e.txd, e.done, e.fail, e.arate, e.wc);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1);
    end

    initial begin : stim
        int r;
        rate_sel = 2'd0; cdv_init = 1'b0; pcsrst = 1'b0; rx_data = '0; rx_kchar = '0;
        cur_rs = 2'd0; cur_ci = 1'b0;
        do_reset("reset_state");
        repeat (20) word("idle_hold");

        cur_rs = 2'd1;
        repeat (RATE_SETTLE + 2) word("settle_r1");
        cur_ci = 1'b1;
        repeat (5) word("hunt_wait");
        comma("comma_first");
        repeat (CDV_WORDS - 1) word("count_pass");
        repeat (3) word("ok_hold");
        cur_ci = 1'b0;
        repeat (2) word("ok_to_idle");

        cur_rs = 2'd2;
        repeat (RATE_SETTLE + 1) word("settle_r2");
        cur_ci = 1'b1;
        word("enter_hunt");
        comma("comma_pre_bad");
        repeat (5) word("count_pre_bad");
        drive(1'b0, 16'($urandom), 2'b10, "bad_word");
        repeat (4) word("hunt_no_comma");
        comma("comma_after_bad");
        repeat (CDV_WORDS - 1) word("count_after_bad");
        word("ok_after_bad");
        cur_ci = 1'b0;
        repeat (2) word("ok_to_idle2");

        cur_rs = 2'd3;
        repeat (RATE_SETTLE + 1) word("settle_r3");
        cur_ci = 1'b1;
        repeat (CDV_TIMEOUT + 5) word("hunt_timeout");
        cur_ci = 1'b0;
        repeat (2) word("fail_release");
        cur_ci = 1'b1;
        word("retry_hunt");
        comma("retry_comma");
        repeat (CDV_WORDS - 1) word("retry_count");
        word("retry_ok");

        cur_rs = 2'd0;
        drive(1'b1, 16'($urandom), 2'b00, "chg_with_pcsrst");
        repeat (RATE_SETTLE + 2) word("settle_r0");
        comma("comma_pre_rst");
        repeat (4) word("count_pre_rst");
        do_reset("rst_mid_count");

        for (int i = 0; i < 900; i++) begin
            if (i == 450) begin
                do_reset("rst_random");
                cur_rs = 2'd2;
            end
            if ($urandom_range(99) < 2) cur_rs = 2'($urandom);
            if ($urandom_range(99) < 1) cur_ci = !cur_ci;
            r = $urandom_range(99);
            if ($urandom_range(149) == 0)
                drive(1'b1, 16'($urandom), 2'($urandom), "rand_pcsrst");
            else if (r < 8)
                comma("rand_comma");
            else if (r < 12)
                drive(1'b0, {8'($urandom), 8'hBC}, {1'b1, 1'($urandom)}, "rand_err");
            else if (r < 15)
                drive(1'b0, {8'($urandom), 8'h3C}, 2'b01, "rand_badk");
            else
                word("rand_word");
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge wrd_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
